// File: rtl/seq_rec_pkg.sv
// Shared state encodings for the 3-ones sequence recognizer controller and its detector core.
package seq_rec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  // Detector state counts consecutive ones seen so far, saturating at two.
  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2
  } det_state_e;

endpackage

// File: rtl/seq_rec_core.sv
// Mealy recognizer: d_out pulses in the cycle the third (or later) consecutive 1 arrives.
// en low returns the detector to its empty state so runs never span words.
module seq_rec_core
  import seq_rec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d_in,
  output logic d_out
);

  det_state_e state_q;
  det_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DET_S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = DET_S0;
    d_out   = 1'b0;
    if (en && d_in) begin
      case (state_q)
        DET_S0:  state_d = DET_S1;
        DET_S1:  state_d = DET_S2;
        DET_S2: begin
          state_d = DET_S2;
          d_out   = 1'b1;
        end
        default: state_d = DET_S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_rec_ctrl.sv
// Word-serial 3-ones recognizer: accepts a word, shifts it LSB first through the detector,
// then holds hit_cnt/hit_mask in DONE until the consumer takes it (abort or reset cancels).
module seq_rec_ctrl
  import seq_rec_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [WIDTH-1:0] hit_mask,
  output logic             busy
);

  localparam int               IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] bit_idx;
  logic             load;
  logic             step;
  logic             det_en;
  logic             det_hit;

  seq_rec_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (det_en),
    .d_in  (shift_reg[0]),
    .d_out (det_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    det_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          det_en = 1'b1;
          step   = 1'b1;
          if (bit_idx == LAST) state_d = DONE;
        end
      end
      // abort wins over out_ready; both land in IDLE but only a handshake counts as delivery.
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      hit_cnt   <= '0;
      hit_mask  <= '0;
    end else if (load) begin
      shift_reg <= in_data;
      bit_idx   <= '0;
      hit_cnt   <= '0;
      hit_mask  <= '0;
    end else if (step) begin
      shift_reg <= shift_reg >> 1;
      bit_idx   <= bit_idx + IDX_W'(1);
      if (det_hit) begin
        hit_mask <= hit_mask | (WIDTH'(1) << bit_idx);
        hit_cnt  <= hit_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_rec_ctrl.sv
// Bench for seq_rec_ctrl: directed corner words plus random words against a run-scanning model.
module tb_seq_rec_ctrl;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] hit_cnt;
  logic [W-1:0]  hit_mask;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_rec_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit_cnt   (hit_cnt),
    .hit_mask  (hit_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A bit is a hit when it closes a run of at least three ones within the word.
  function automatic logic [W-1:0] model_mask(input logic [W-1:0] d);
    logic [W-1:0] m;
    m = '0;
    for (int i = 2; i < W; i++)
      if (d[i] && d[i-1] && d[i-2]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic run_word(input logic [W-1:0] d, input int hold,
                          input int exp_cnt, input logic [W-1:0] exp_mask);
    int lat;
    accept(d);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    chk("latency", 32'(lat), 32'(W));
    chk("hit_cnt", 32'(hit_cnt), 32'(exp_cnt));
    chk("hit_mask", 32'(hit_mask), 32'(exp_mask));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_cnt", 32'(hit_cnt), 32'(exp_cnt));
      chk("hold_mask", 32'(hit_mask), 32'(exp_mask));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] m;
    int           seen;
    int           lat;

    #12 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_mask", 32'(hit_mask), 32'd0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_in_ready", 32'(in_ready), 32'd1);
    chk("idle_abort_busy", 32'(busy), 32'd0);

    run_word(16'h0007, 0, 1, 16'h0004);
    run_word(16'hFFFF, 0, 14, 16'hFFFC);
    run_word(16'h7777, 1, 4, 16'h4444);
    run_word(16'h0000, 0, 0, 16'h0000);
    run_word(16'hC000, 0, 0, 16'h0000);
    run_word(16'h0001, 0, 0, 16'h0000);
    run_word(16'h0007, 5, 1, 16'h0004);

    // Abort while bit 7 is being processed.
    accept(16'hFFFF);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_word(16'h0E07, 0, 2, 16'h0804);

    // Abort together with out_ready in DONE: no delivery, back to IDLE.
    accept(16'h00F0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("done_reached", 32'(out_valid), 32'd1);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("done_abort_valid", 32'(out_valid), 32'd0);
    chk("done_abort_in_ready", 32'(in_ready), 32'd1);
    run_word(16'h1F00, 0, 3, 16'h1C00);

    // Asynchronous reset mid-word, away from any clock edge.
    accept(16'hFFFF);
    repeat (8) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(hit_cnt), 32'd0);
    chk("arst_mask", 32'(hit_mask), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    run_word(16'h0007, 0, 1, 16'h0004);

    repeat (30) begin
      d = W'($urandom);
      m = model_mask(d);
      run_word(d, int'($urandom_range(0, 3)), $countones(m), m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_rec_ctrl.md
SEQ_REC_CTRL -- requirements
Module: seq_rec_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bits per word (legal range 3..32).
REQ-002 The block SHALL have localparam CNT_W, default $clog2(WIDTH+1), giving the hit-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a word is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the controller accepts a word.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the word, shifted out LSB first.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of the word in progress.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port hit_cnt, output, CNT_W bits: the number of detections in the word.
REQ-012 The block SHALL have port hit_mask, output, WIDTH bits: bit i set when a detection occurred on bit i.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid&in_ready the FSM SHALL load the shift register, clear hit_cnt/hit_mask/bit index, and go to SHIFT.
REQ-016 In SHIFT, each cycle SHALL drive detector en=1 and d_in=shift_reg[0], shift right by one, and increment the bit index.
REQ-017 The detector SHALL flag bit i when bits i, i-1 and i-2 of the current word are all 1 (overlapping runs: 0xF gives hits at bits 2 and 3).
REQ-018 On a flagged bit, hit_mask[i] SHALL be set and hit_cnt SHALL increment in the same cycle.
REQ-019 After bit WIDTH-1 is processed, the FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-020 In DONE, out_valid=1 and hit_cnt/hit_mask SHALL hold stable until out_valid&out_ready, then the FSM SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; no word is accepted in the cycle the result is taken, so the minimum issue interval is WIDTH+2 cycles.
REQ-022 Detector en SHALL be 0 outside SHIFT, forcing the detector to its idle state so that no run carries across words.
REQ-023 abort high in SHIFT or DONE SHALL return the FSM to IDLE next edge with out_valid=0 and no result delivered; abort in IDLE SHALL be ignored.
REQ-024 abort SHALL take priority over out_ready in the same cycle.
REQ-025 hit_cnt SHALL never wrap (maximum WIDTH-2, fits CNT_W).

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, shift register, bit index, hit_cnt and hit_mask to 0, and out_valid=0, busy=0, in_ready=1 (after reset is released).
REQ-027 Reset mid-SHIFT SHALL discard the word, and the first post-reset word SHALL behave as from power-up.

Structure
REQ-028 Package seq_rec_pkg SHALL hold the controller state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the detector state encodings.
REQ-029 The detector SHALL be sub-module seq_rec_core (clk, rst_n, en, d_in, d_out), a Mealy 3-ones recognizer with registered state, all next-state and output paths fully assigned, and no latches.

Verification
REQ-030 The bench SHALL check that WIDTH=16, in_data=0x0007 gives hit_cnt=1 and hit_mask=0x0004, with out_valid 16 cycles after acceptance.
REQ-031 The bench SHALL check that 0xFFFF gives hit_cnt=14, hit_mask=0xFFFC; 0x7777 gives hit_cnt=4, hit_mask=0x4444; 0x0000 gives 0/0x0000.
REQ-032 The bench SHALL check that 0xC000 followed by 0x0001 gives hit_cnt=0 for both words (no carry across words).
REQ-033 The bench SHALL check that out_ready held low 5 cycles in DONE keeps out_valid=1 with outputs stable and in_ready=0, and that in_ready=1 appears the cycle after the handshake.
REQ-034 The bench SHALL check that abort at bit index 7 of 0xFFFF gives no out_valid, a return to IDLE, and a correct next word.
REQ-035 The bench SHALL check that rst_n asserted mid-SHIFT immediately clears out_valid, busy, hit_cnt and hit_mask, and that 0x0007 then still yields 1/0x0004.
